fifo_buffer: RTL and testbench

FIFO_BUFFER -- requirements
Module: fifo_buffer

---
 rtl/fifo_buffer.sv | 45 ++++
 tb/tb_fifo_buffer.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock FIFO with a programmable full threshold and 1-cycle registered read data.
module fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  write_enable,
  input  logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   full_thres,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_V = DEPTH[ADDR_WIDTH:0];
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0] count, th;
  logic wr_ok, rd_ok;
  // A zero or out-of-range threshold falls back to the full memory depth.
  assign th = (full_thres == '0 || full_thres > DEPTH_V) ? DEPTH_V : full_thres;
  assign full = count >= th;
  assign empty = count == '0;
  assign wr_ok = write_enable && !full && reset_n;
  assign rd_ok = read_enable && !empty && reset_n;
  always_ff @(posedge clock)
    if (wr_ok) mem[wr_ptr] <= data_in;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      data_out <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
        data_out <= mem[rd_ptr];
      end
      count <= (wr_ok && !rd_ok) ? count + (ADDR_WIDTH+1)'(1) :
               (rd_ok && !wr_ok) ? count - (ADDR_WIDTH+1)'(1) : count;
    end
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: randomized scoreboard bench for fifo_buffer against a queue-based reference model.
module tb_fifo_buffer;
  logic clk = 0, reset_n = 0, write_enable = 0, read_enable = 0;
  logic [7:0] data_in = 0, data_out;
  logic [5:0] full_thres = 6'd32;
  logic empty, full;
  int checks = 0, errors = 0;
  logic [7:0] model_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] last = 0;

  fifo_buffer dut (
    .clock(clk), .reset_n(reset_n), .write_enable(write_enable), .read_enable(read_enable),
    .data_in(data_in), .full_thres(full_thres), .data_out(data_out), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int eff_th(input logic [5:0] t);
    return (t == 0 || t > 32) ? 32 : int'(t);
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic we, input logic re, input logic [7:0] d);
    bit wa, ra;
    write_enable = we;
    read_enable = re;
    data_in = d;
    #1;
    chk("empty", int'(empty), int'(model_q.size() == 0));
    chk("full", int'(full), int'(model_q.size() >= eff_th(full_thres)));
    wa = we && model_q.size() < eff_th(full_thres);
    ra = re && model_q.size() > 0;
    if (ra) exp_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    write_enable = 0;
    read_enable = 0;
    #2 reset_n = 0;
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_data_out", int'(data_out), 0);
    model_q.delete();
    exp_q.delete();
    last = 0;
    @(negedge clk);
    #2 reset_n = 1;
    @(negedge clk);
  endtask

  initial begin : monitor
    bit rd;
    forever begin
      @(negedge clk);
      #3 rd = read_enable && !empty && reset_n;
      @(posedge clk);
      #1;
      if (rd) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read: data_out %0d with no expected word", data_out);
        end else begin
          last = exp_q.pop_front();
          chk("read_data", int'(data_out), int'(last));
        end
      end else chk("data_out_hold", int'(data_out), int'(last));
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("init_empty", int'(empty), 1);
    chk("init_full", int'(full), 0);
    chk("init_data_out", int'(data_out), 0);
    #1 reset_n = 1;
    @(negedge clk);
    full_thres = 32;
    repeat (50) step(1, 0, 8'd120);
    repeat (40) step(0, 1, 8'd0);
    full_thres = 4;
    for (int i = 1; i <= 5; i++) step(1, 0, 8'(i));
    repeat (5) step(0, 1, 8'd0);
    full_thres = 32;
    repeat (30) step(1, 0, 8'($urandom));
    repeat (28) step(0, 1, 8'd0);
    repeat (10) step(1, 1, 8'($urandom));
    repeat (3) step(0, 1, 8'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 8'(40 + i));
    do_reset();
    step(1, 0, 8'd99);
    step(0, 1, 8'd0);
    step(0, 0, 8'd0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) full_thres = 6'($urandom_range(0, 63));
      if (i == 200) full_thres = 2;
      if (i == 203) full_thres = 32;
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), 8'($urandom));
    end
    full_thres = 32;
    repeat (34) step(0, 1, 8'd0);
    step(0, 0, 8'd0);
    chk("drain_pending", exp_q.size(), 0);
    chk("drain_model", model_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
